// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
//   Parametrised universal shift register. Supports hold, parallel load and
//   clear, logical/arithmetic shifts and rotates, and a burst mode that
//   repeats a latched shift operation N times under FSM control. The serial
//   add/sub datapath uses the burst mode to stream operands in and results
//   out one bit per cycle.
//
// Parameters
//   WIDTH  register width (>= 2)
//   CNT_W  burst count width (2**CNT_W > WIDTH)
//
// Ports
//   clk     rising-edge clock
//   reset   synchronous active-high reset
//   en      clock enable; low freezes everything (done forced low)
//   mode    operation select:
//             000 HOLD, 001 SHL, 010 SHR, 011 ROL,
//             100 ROR,  101 LOAD, 110 ASR, 111 CLR
//   d       parallel load data
//   sin_l   serial input entering at the MSB on right shifts
//   sin_r   serial input entering at the LSB on left shifts
//   start   burst request, sampled in IDLE together with nshift
//   nshift  number of shifts in the burst
//   q       register contents
//   sout_l  q[WIDTH-1]
//   sout_r  q[0]
//   busy    registered, high while a burst is running
//   done    registered, one-cycle pulse when a burst completes
// ---------------------------------------------------------------------------
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CNT_W-1:0] nshift,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_ROL  = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_LOAD = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_lat_q, mode_lat_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // One step of the selected operation applied to the current contents.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] ld,
        input logic             in_l,
        input logic             in_r
    );
        logic [WIDTH-1:0] res;
        res = cur;
        case (op)
            M_HOLD: res = cur;
            M_SHL:  res = {cur[WIDTH-2:0], in_r};
            M_SHR:  res = {in_l, cur[WIDTH-1:1]};
            M_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROR:  res = {cur[0], cur[WIDTH-1:1]};
            M_LOAD: res = ld;
            M_ASR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            M_CLR:  res = '0;
            default: res = cur;
        endcase
        return res;
    endfunction

    // Only shifting/rotating modes make sense to repeat in a burst.
    function automatic logic is_shift(input logic [2:0] op);
        return (op == M_SHL) || (op == M_SHR) || (op == M_ROL) ||
               (op == M_ROR) || (op == M_ASR);
    endfunction

    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        cnt_d      = cnt_q;
        mode_lat_d = mode_lat_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (start && is_shift(mode)) begin
                        // The accepting edge only captures the request; q holds.
                        mode_lat_d = mode;
                        cnt_d      = nshift;
                        if (nshift == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_BURST;
                            busy_d  = 1'b1;
                        end
                    end else begin
                        q_d = apply_op(mode, q_q, d, sin_l, sin_r);
                    end
                end
                ST_BURST: begin
                    q_d   = apply_op(mode_lat_q, q_q, d, sin_l, sin_r);
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            q_q        <= '0;
            cnt_q      <= '0;
            mode_lat_q <= M_HOLD;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            cnt_q      <= cnt_d;
            mode_lat_q <= mode_lat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign q      = q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_univ_shift_reg
//   Directed scenarios followed by randomized traffic, every edge compared
//   against an arithmetic reference model of the register (WIDTH=8).
// ---------------------------------------------------------------------------
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       reset, en, sin_l, sin_r, start;
    logic [2:0] mode;
    logic [7:0] d;
    logic [3:0] nshift;
    logic [7:0] q;
    logic       sout_l, sout_r, busy, done;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: value as an integer, plus remaining burst shifts.
    int mq, mrem, mmode;
    int mbusy, mdone;

    univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .start(start), .nshift(nshift),
        .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int op_value(input int m, input int v);
        case (m)
            1: return (v * 2 + int'(sin_r)) % 256;
            2: return v / 2 + int'(sin_l) * 128;
            3: return (v * 2) % 256 + v / 128;
            4: return v / 2 + (v % 2) * 128;
            5: return int'(d);
            6: return v / 2 + (v / 128) * 128;
            7: return 0;
            default: return v;
        endcase
    endfunction

    function automatic bit shift_mode(input int m);
        return m == 1 || m == 2 || m == 3 || m == 4 || m == 6;
    endfunction

    task automatic model_edge();
        if (reset) begin
            mq = 0; mrem = 0; mmode = 0; mbusy = 0; mdone = 0;
        end else if (!en) begin
            mdone = 0;
        end else if (mrem > 0) begin
            mq    = op_value(mmode, mq);
            mrem  = mrem - 1;
            mdone = (mrem == 0);
            mbusy = (mrem != 0);
        end else begin
            mdone = 0;
            if (start && shift_mode(int'(mode))) begin
                mmode = int'(mode);
                if (nshift == 0) mdone = 1;
                else begin
                    mrem  = int'(nshift);
                    mbusy = 1;
                end
            end else begin
                mq = op_value(int'(mode), mq);
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model, then compare everything after the edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".q"}, int'(q), mq);
        chk({tag, ".busy"}, int'(busy), mbusy);
        chk({tag, ".done"}, int'(done), mdone);
        chk({tag, ".sout_l"}, int'(sout_l), mq / 128);
        chk({tag, ".sout_r"}, int'(sout_r), mq % 2);
        $display("%0t %s mode=%0d q=%h busy=%0d done=%0d", $time, tag, mode, q, busy, done);
    endtask

    task automatic load(input logic [7:0] v);
        mode = 3'b101; d = v; start = 1'b0;
        tick("load");
    endtask

    initial begin
        logic [7:0] bits;
        reset = 1'b1; en = 1'b1; mode = 3'b101; d = 8'hA5;
        sin_l = 1'b0; sin_r = 1'b0; start = 1'b0; nshift = 4'd0;
        mq = 0; mrem = 0; mmode = 0; mbusy = 0; mdone = 0;

        // Reset and load/clear
        tick("rst0"); tick("rst1");
        chk("rst.q_lit", int'(q), 8'h00);
        reset = 1'b0;
        tick("ld_a5"); chk("ld.q_lit", int'(q), 8'hA5);
        mode = 3'b111; tick("clr"); chk("clr.q_lit", int'(q), 8'h00);

        // Direct shifts
        load(8'h81);
        mode = 3'b001; sin_r = 1'b0; tick("shl"); chk("shl.q_lit", int'(q), 8'h02);
        mode = 3'b010; sin_l = 1'b1; tick("shr"); chk("shr.q_lit", int'(q), 8'h81);
        mode = 3'b011; tick("rol"); chk("rol.q_lit", int'(q), 8'h03);
        mode = 3'b110; tick("asr"); chk("asr.q_lit", int'(q), 8'h01);

        // Burst rotate, mode changed during the burst
        load(8'h01);
        mode = 3'b011; start = 1'b1; nshift = 4'd3; tick("brol_go");
        chk("brol_go.q_lit", int'(q), 8'h01);
        start = 1'b0; mode = 3'b101; d = 8'hFF;
        tick("brol1"); chk("brol1.q_lit", int'(q), 8'h02);
        tick("brol2"); chk("brol2.q_lit", int'(q), 8'h04);
        tick("brol3"); chk("brol3.q_lit", int'(q), 8'h08);
        chk("brol3.done_lit", int'(done), 1);
        mode = 3'b000; tick("brol_post"); chk("brol_post.done_lit", int'(done), 0);

        // Stall mid-burst, then zero count
        load(8'h10);
        mode = 3'b100; start = 1'b1; nshift = 4'd4; tick("bror_go");
        start = 1'b0;
        tick("bror1");
        en = 1'b0; tick("stall1"); tick("stall2");
        chk("stall.q_lit", int'(q), 8'h08);
        en = 1'b1;
        tick("bror2"); tick("bror3"); tick("bror4");
        chk("bror.q_lit", int'(q), 8'h01);
        mode = 3'b100; start = 1'b1; nshift = 4'd0; tick("zero_go");
        chk("zero.done_lit", int'(done), 1);
        start = 1'b0; mode = 3'b000; tick("zero_post");

        // Abort by reset, then start with LOAD is a plain load
        load(8'h55);
        mode = 3'b001; start = 1'b1; nshift = 4'd5; tick("abort_go");
        start = 1'b0; tick("abort1");
        reset = 1'b1; tick("abort_rst");
        reset = 1'b0; mode = 3'b101; d = 8'h3C; start = 1'b1; nshift = 4'd3;
        tick("start_load"); chk("start_load.q_lit", int'(q), 8'h3C);
        start = 1'b0;

        // Serial stream in from the LSB
        mode = 3'b111; tick("ser_clr");
        mode = 3'b001; start = 1'b1; nshift = 4'd8; tick("ser_go");
        start = 1'b0;
        bits = 8'b1011_0010;
        for (int i = 7; i >= 0; i--) begin
            sin_r = bits[i];
            tick("ser");
        end
        chk("ser.q_lit", int'(q), 8'hB2);
        chk("ser.done_lit", int'(done), 1);

        // Randomized traffic, including back-to-back bursts and long counts
        for (int i = 0; i < 600; i++) begin
            reset  = ($urandom_range(0, 99) < 2);
            en     = ($urandom_range(0, 99) < 85);
            mode   = 3'($urandom_range(0, 7));
            d      = 8'($urandom);
            sin_l  = 1'($urandom);
            sin_r  = 1'($urandom);
            start  = ($urandom_range(0, 99) < 30);
            nshift = 4'($urandom_range(0, 15));
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register, the successor to the single-bit D flip-flop storage element used in the add/sub datapath.
- Provides parallel load, hold and clear.
- Provides logical and arithmetic shifts and rotates, with serial inputs and outputs at both ends.
- Provides a burst mode that performs N back-to-back shifts under FSM control; the serial add/sub datapath uses it to stream operands and collect results bit by bit.

Parameters:
- WIDTH, 8, register width in bits; must be at least 2.
- CNT_W, 4, width of the burst shift count; 2**CNT_W must be greater than WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- en  input  1  clock enable; when low, all state holds, including the FSM and the burst counter.
- mode  input  3  operation select (encoding in Behaviour).
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial input entering at the MSB (shift right).
- sin_r  input  1  serial input entering at the LSB (shift left).
- start  input  1  burst request; sampled only in IDLE.
- nshift  input  CNT_W  burst shift count; sampled together with start.
- q  output  WIDTH  register contents.
- sout_l  output  1  q[WIDTH-1], combinational from q.
- sout_r  output  1  q[0], combinational from q.
- busy  output  1  high while the FSM is in BURST.
- done  output  1  one-cycle pulse on burst completion.

Behaviour:
- Reset (synchronous, active-high):
  - q=0, busy=0, done=0, FSM=IDLE, burst counter=0, latched mode=000.
  - Reset overrides en, start and any burst in progress.
- Priority per edge: reset > en low (full hold; done forced to 0) > BURST operation > direct mode operation.
- Mode encoding, one operation per enabled edge:
  - 000 HOLD: q unchanged.
  - 001 SHL: q <= {q[WIDTH-2:0], sin_r}.
  - 010 SHR: q <= {sin_l, q[WIDTH-1:1]}.
  - 011 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 100 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 101 LOAD: q <= d.
  - 110 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}; sin_l is ignored.
  - 111 CLR: q <= 0.
- FSM states: IDLE, BURST.
- IDLE:
  - Applies mode directly every enabled edge.
  - If start=1 and mode is one of the shift modes (001, 010, 011, 100, 110), the edge does the following:
    - Latches mode and nshift.
    - Performs no operation on q during that edge (q holds).
    - If nshift=0: stays in IDLE and sets done=1 for the next cycle.
    - Otherwise: goes to BURST with busy=1.
  - start together with HOLD, LOAD or CLR: start is ignored and the mode is applied normally.
- BURST:
  - Each enabled edge applies the latched mode once and decrements the counter.
  - The edge that performs the last shift sets FSM=IDLE, busy=0 and done=1. done stays high for exactly one cycle.
  - Timing: q changes exactly nshift times, on the nshift enabled edges after the start edge.
  - Inputs mode, start, nshift and d are ignored in BURST.
  - sin_l and sin_r are sampled live on every burst shift.
- en low during BURST: the burst stalls, with counter, q and busy frozen. It resumes when en returns high.
- Outputs done and busy are registered. sout_l and sout_r are combinational from q only.
- nshift greater than WIDTH is legal: shifts continue, and a rotate wraps around repeatedly.
- Back-to-back bursts: start may be asserted on the cycle done is high (FSM already IDLE); the new burst is accepted.
- Reset asserted mid-burst: the burst aborts and done is not pulsed.

Test Plan (WIDTH=8):
- Reset/load: assert reset 2 cycles, then mode=101, d=8'hA5, en=1 -> q=00 during reset, q=A5 after 1 edge; then mode=111 -> q=00.
- Direct shifts: q=8'h81; apply SHL sin_r=0, then SHR sin_l=1, then ROL, then ASR -> q=02, then 81, then 03, then 01; sout_l/sout_r track q[7]/q[0].
- Burst rotate: q=8'h01, mode=011, start=1, nshift=3 -> busy=1 for 3 cycles; q=02, 04, 08; done=1 for one cycle as busy falls; mode changes during the burst have no effect.
- Stall and zero count: burst ROR with nshift=4 from q=8'h10, en=0 for 2 cycles mid-burst -> q frozen, busy held, final q=01, done once; then start with nshift=0 -> no busy, done pulse next cycle, q unchanged.
- Abort and ignore: reset asserted on the 2nd burst cycle -> q=00, busy=0, no done; start with mode=101 -> plain load, busy stays 0.
- Serial stream: q=8'h00, burst SHL with nshift=8, sin_r driven 1,0,1,1,0,0,1,0 -> q=8'hB2 at done.
